// File: rtl/burst_fifo.sv
// burst_fifo: single-clock FIFO with burst-granular handshake.
//   Pointers carry an extra wrap bit so full and empty are never ambiguous.
//   Ports:
//     clk_i, rst_i            clock, asynchronous active-high reset
//     flush_i                 synchronous clear of pointers, beat count, errors
//     drain_i                 let partial bursts out (out_val_o on any data)
//     clr_err_i               synchronous clear of ovf_o / udf_o
//     in_incr_i, in_data_i    push strobe and data
//     in_rdy_o                room for at least one whole burst
//     out_incr_i              pop strobe
//     out_data_o              head entry (combinational)
//     out_val_o, out_last_o   burst available / head is last beat of burst
//     level_o                 occupancy 0..LEN
//     ovf_o, udf_o            sticky push-while-full / pop-while-empty
module burst_fifo #(
    parameter int unsigned WLEN      = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             drain_i,
    input  logic             clr_err_i,
    input  logic             in_incr_i,
    input  logic [DEPTH-1:0] in_data_i,
    output logic             in_rdy_o,
    input  logic             out_incr_i,
    output logic [DEPTH-1:0] out_data_o,
    output logic             out_val_o,
    output logic             out_last_o,
    output logic [WLEN:0]    level_o,
    output logic             ovf_o,
    output logic             udf_o
);

    localparam int unsigned LEN = 1 << WLEN;
    localparam int unsigned BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WLEN:0]  LEN_V   = (WLEN+1)'(LEN);
    localparam logic [WLEN:0]  BURST_V = (WLEN+1)'(BURST_LEN);
    localparam logic [BCW-1:0] BLAST   = BCW'(BURST_LEN - 1);

    logic [DEPTH-1:0] mem [LEN];
    logic [WLEN:0]    wptr;
    logic [WLEN:0]    rptr;
    logic [WLEN:0]    level;
    logic [WLEN:0]    space;
    logic [BCW-1:0]   bcnt;
    logic             ovf;
    logic             udf;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             last;

    always_comb begin
        // Modulo subtraction stays correct across pointer wrap.
        level = wptr - rptr;
        space = LEN_V - level;
        empty = (level == '0);
        full  = (level == LEN_V);
        push  = in_incr_i  && !full  && !flush_i;
        pop   = out_incr_i && !empty && !flush_i;
        last  = !empty && ((bcnt == BLAST) || (drain_i && level == (WLEN+1)'(1)));
    end

    always_comb begin
        level_o    = level;
        out_data_o = mem[rptr[WLEN-1:0]];
        in_rdy_o   = !rst_i && (space >= BURST_V);
        out_val_o  = !rst_i && ((level >= BURST_V) || (drain_i && !empty));
        out_last_o = !rst_i && last;
        ovf_o      = ovf;
        udf_o      = udf;
    end

    // Storage has no reset; contents are don't-care after reset or flush.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr[WLEN-1:0]] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            bcnt <= '0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
            bcnt <= '0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
                // A drain-mode last beat ends the burst early.
                if (last) begin
                    bcnt <= '0;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
            // An error event in the same cycle beats clr_err_i.
            if (in_incr_i && full) begin
                ovf <= 1'b1;
            end else if (clr_err_i) begin
                ovf <= 1'b0;
            end
            if (out_incr_i && empty) begin
                udf <= 1'b1;
            end else if (clr_err_i) begin
                udf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_burst_fifo.sv
module tb_burst_fifo;

    localparam int LEN = 256;
    localparam int BL  = 16;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       flush_i = 1'b0;
    logic       drain_i = 1'b0;
    logic       clr_err_i = 1'b0;
    logic       in_incr_i = 1'b0;
    logic [7:0] in_data_i = '0;
    logic       in_rdy_o;
    logic       out_incr_i = 1'b0;
    logic [7:0] out_data_o;
    logic       out_val_o;
    logic       out_last_o;
    logic [8:0] level_o;
    logic       ovf_o;
    logic       udf_o;

    burst_fifo #(.WLEN(8), .DEPTH(8), .BURST_LEN(BL)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .drain_i(drain_i),
        .clr_err_i(clr_err_i), .in_incr_i(in_incr_i), .in_data_i(in_data_i),
        .in_rdy_o(in_rdy_o), .out_incr_i(out_incr_i), .out_data_o(out_data_o),
        .out_val_o(out_val_o), .out_last_o(out_last_o), .level_o(level_o),
        .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored data plus occupancy, burst position
    // and sticky error bits.
    logic [7:0] sb[$];
    int  mlevel = 0;
    int  mpos   = 0;
    bit  movf   = 0;
    bit  mudf   = 0;
    bit  exp_pop = 0;
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: whenever a pop is due to be accepted, the head must match
    // the oldest accepted push.
    always @(negedge clk) begin
        if (exp_pop) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL data: got %0d expected none (scoreboard empty)", out_data_o);
            end else begin
                chk("data", int'(out_data_o), int'(sb.pop_front()));
            end
        end
    end

    task automatic cyc(input bit push, input logic [7:0] d, input bit pop,
                       input bit fl, input bit clr);
        bit full, empty, wok, pok, exp_last;
        in_incr_i  = push;
        in_data_i  = d;
        out_incr_i = pop;
        flush_i    = fl;
        clr_err_i  = clr;
        empty = (mlevel == 0);
        full  = (mlevel == LEN);
        wok   = push && !full && !fl;
        pok   = pop && !empty && !fl;
        exp_last = !empty && (mpos == BL - 1 || (drain_i && mlevel == 1));
        exp_pop = pok;
        @(negedge clk);
        chk("level", int'(level_o), mlevel);
        chk("in_rdy", int'(in_rdy_o), int'(LEN - mlevel >= BL));
        chk("out_val", int'(out_val_o), int'(mlevel >= BL || (drain_i && mlevel != 0)));
        chk("out_last", int'(out_last_o), int'(exp_last));
        chk("ovf", int'(ovf_o), int'(movf));
        chk("udf", int'(udf_o), int'(mudf));
        @(posedge clk);
        if (fl) begin
            sb.delete();
            mlevel = 0;
            mpos = 0;
            movf = 0;
            mudf = 0;
        end else begin
            if (wok) sb.push_back(d);
            if (pok) mpos = exp_last ? 0 : mpos + 1;
            mlevel = mlevel + int'(wok) - int'(pok);
            if (push && full) movf = 1;
            else if (clr) movf = 0;
            if (pop && empty) mudf = 1;
            else if (clr) mudf = 0;
        end
        exp_pop = 0;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_level"}, int'(level_o), 0);
        chk({tag, "_in_rdy"}, int'(in_rdy_o), 0);
        chk({tag, "_out_val"}, int'(out_val_o), 0);
        chk({tag, "_out_last"}, int'(out_last_o), 0);
        chk({tag, "_ovf"}, int'(ovf_o), 0);
        chk({tag, "_udf"}, int'(udf_o), 0);
    endtask

    initial begin
        // Reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 rst_i = 1'b0;

        // One burst of 0x00..0x0F in, then out with last on beat 16.
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, '0, 1, 0, 0);

        // Fill completely, overflow, clear error.
        for (int i = 0; i < LEN; i++) cyc(1, 8'($urandom), 0, 0, 0);
        cyc(1, 8'hAA, 0, 0, 0);
        cyc(0, '0, 0, 0, 1);
        // Full with simultaneous push and pop: pop wins, push rejected.
        cyc(1, 8'h55, 1, 0, 0);
        cyc(0, '0, 0, 0, 1);

        // Drain to empty, then underflow and push+pop on empty.
        while (mlevel > 0) cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(1, 8'h3C, 1, 0, 0);
        cyc(0, '0, 1, 0, 1);
        cyc(0, '0, 0, 0, 0);

        // Partial burst released by drain mode.
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h80 + i), 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        drain_i = 1'b1;
        for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0, 0);
        drain_i = 1'b0;
        cyc(0, '0, 0, 0, 0);

        // Constant-level stream across several pointer wraps.
        for (int i = 0; i < 20; i++) cyc(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 1000; i++) cyc(1, 8'($urandom), 1, 0, 0);

        // Flush at level 50 with simultaneous push and pop.
        while (mlevel < 50) cyc(1, 8'($urandom), 0, 0, 0);
        cyc(1, 8'h11, 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(1, 8'h22, 1, 1, 0);
        cyc(0, '0, 0, 0, 0);

        // Random traffic, biased alternately towards filling and draining.
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 300; i++) begin
                int pp;
                pp = (ph % 2 == 0) ? 80 : 25;
                if ($urandom_range(0, 19) == 0) drain_i = ~drain_i;
                cyc($urandom_range(0, 99) < pp, 8'($urandom),
                    $urandom_range(0, 99) < (100 - pp),
                    $urandom_range(0, 199) == 0,
                    $urandom_range(0, 19) == 0);
            end
        end
        drain_i = 1'b0;

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 30; i++) cyc(1, 8'($urandom), 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 0, 0, 1);
        in_incr_i = 1'b0;
        out_incr_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        mlevel = 0;
        mpos = 0;
        movf = 0;
        mudf = 0;
        @(posedge clk);
        #1 rst_i = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'hC0 + i), 0, 0, 0);
        drain_i = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0);
        drain_i = 1'b0;
        cyc(0, '0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_fifo.md
# burst_fifo

Parametrised single-clock burst FIFO for the DDR frame path, replacing the separate read-side and write-side FIFOs with one block. It uses full-width pointers with an extra wrap bit, so full and empty are never ambiguous. It exposes occupancy, burst-granular ready/valid, a last-beat marker, a drain mode for partial final bursts, synchronous flush, and sticky overflow/underflow error flags.

## Interface
- WLEN, 8: address bits; capacity LEN = 2^WLEN entries.
- DEPTH, 8: data bits per entry.
- BURST_LEN, 16: burst size in entries; legal range 2..LEN/2.
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous clear of pointers, beat counter and error flags.
- drain_i  in  1  level; when high, out_val_o asserts for any nonzero occupancy.
- clr_err_i  in  1  synchronous clear of ovf_o/udf_o.
- in_incr_i  in  1  push in_data_i this cycle.
- in_data_i  in  DEPTH  write data.
- in_rdy_o  out  1  space for at least one full burst.
- out_incr_i  in  1  pop the head entry this cycle.
- out_data_o  out  DEPTH  head entry, combinational from memory.
- out_val_o  out  1  at least one full burst available (or data present in drain mode).
- out_last_o  out  1  current head beat is the last of a burst.
- level_o  out  WLEN+1  occupancy, 0..LEN.
- ovf_o  out  1  sticky: push attempted while full.
- udf_o  out  1  sticky: pop attempted while empty.

## Operation
- State: wptr, rptr (WLEN+1 bits each), beat counter bcnt (log2(BURST_LEN) bits), ovf, udf, and memory mem[0:LEN-1].
- level = wptr - rptr, computed modulo 2^(WLEN+1).
- empty = (level == 0); full = (level == LEN).
- Push: if in_incr_i && !full, then mem[wptr[WLEN-1:0]] <= in_data_i and wptr increments.
- Push while full: memory and wptr are unchanged, and ovf is set.
- Pop: if out_incr_i && !empty, rptr increments.
  - bcnt increments, and wraps to 0 after BURST_LEN-1.
  - bcnt also returns to 0 on a pop that occurs while out_last_o is high.
- Pop while empty: pointers and bcnt are unchanged, and udf is set.
- Simultaneous push and pop:
  - Both succeed when neither full nor empty.
  - When full, the pop succeeds and the push is rejected (ovf set).
  - When empty, the push succeeds and the pop is rejected (udf set). No bypass.
- in_rdy_o = !rst_i && (LEN - level >= BURST_LEN).
- out_val_o = !rst_i && (level >= BURST_LEN || (drain_i && level != 0)).
- out_last_o = !rst_i && !empty && (bcnt == BURST_LEN-1 || (drain_i && level == 1)).
- flush_i has priority over all pushes and pops that cycle.
  - Next state: wptr = rptr = 0, bcnt = 0, ovf = udf = 0.
  - Memory contents are don't-care.
- clr_err_i clears both flags. An error event in the same cycle wins, so the flag stays set.
- Pointer wrap past 2^(WLEN+1) is natural modulo arithmetic. level stays correct across the wrap.

## Timing
- Reset values while rst_i is high and after its release: pointers 0, bcnt 0, level_o 0, in_rdy_o 0 (forced during reset), then 1 after release; out_val_o 0, out_last_o 0, ovf_o 0, udf_o 0.
- Reset mid-operation clears all of the above immediately; buffered data is lost.
- Flags and level_o are combinational from registered state. They reflect a push or pop one cycle after the accepting edge.
- Write-to-read latency is 1 cycle: an entry pushed at edge N is visible on out_data_o after edge N when it is at the head.
- Handshake: the producer may push up to BURST_LEN beats after sampling in_rdy_o high without re-checking. The consumer may pop BURST_LEN beats after sampling out_val_o high. in_rdy_o and out_val_o are not beat-level flow control.

## Test plan
- Reset, then 16 pushes of 0x00..0x0F (WLEN=8, BURST_LEN=16) -> out_val_o rises after the 16th edge, level_o=16; 16 pops return 0x00..0x0F and out_last_o is high on the 16th beat only.
- Fill to 256 entries -> level_o=256, in_rdy_o low from level 241 onward; the 257th push leaves level at 256 and sets ovf_o; clr_err_i clears it.
- Pop while empty -> udf_o=1, rptr unchanged; a simultaneous push on empty -> level_o=1, udf_o=1.
- Push 5 entries, out_val_o=0; raise drain_i -> out_val_o=1; out_last_o is high on the 5th pop.
- Stream 1000 push/pop pairs at constant level 20 -> data order preserved across pointer wrap, level_o steady at 20, no error flags.
- Assert flush_i with simultaneous push and pop at level 50 -> next cycle level_o=0 and errors cleared; asserting rst_i mid-burst clears all outputs asynchronously.
